// File: rtl/bnn_pkg.sv
// Shared constants for the binary convolution engine layers.
package bnn_pkg;

  localparam int CONV_DW = 5;
  localparam int W_L1    = 26;
  localparam int W_L2    = 24;
  localparam int POOL    = 2;

  localparam logic LAYER1 = 1'b0;
  localparam logic LAYER2 = 1'b1;

  // Conv output map width for the selected layer
  function automatic int layer_width(input logic sel);
    return (sel == LAYER2) ? W_L2 : W_L1;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-bit-wide line buffer holding the horizontally pooled even row
// until the matching odd row arrives.
module pool_line_buf #(
  parameter int DEPTH = 13,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  logic mem [DEPTH];

  // Synchronous write; contents need no reset since every entry is
  // rewritten on an even row before the next odd row reads it
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bin_maxpool.sv
// Binarizes the signed conv stream against a threshold and applies 2x2
// stride-2 max pooling (logical OR) on the binary map. Serves both conv
// layers; the map width is latched from 'state' at each frame start.
module bin_maxpool
  import bnn_pkg::*;
#(
  parameter int DW    = CONV_DW,
  parameter int MAX_W = W_L1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 state,
  input  logic signed [DW-1:0] thresh,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  input  logic                 din_done,
  output logic                 pool_out,
  output logic                 pool_valid,
  output logic                 pool_done,
  output logic                 frame_err
);

  localparam int CW = $clog2(MAX_W);
  localparam int AW = $clog2(MAX_W / POOL);

  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [CW-1:0] w_reg;
  logic [CW-1:0] w_eff;
  logic [CW-1:0] col_nxt;
  logic [CW-1:0] row_nxt;
  logic          hreg;
  logic          b;
  logic          h;
  logic          frame_start;
  logic          last_col;
  logic          last_row;
  logic          pair_out;
  logic          lb_we;
  logic          lb_rd;
  logic [AW-1:0] lb_idx;

  // Beat decode: binarize, pick the width in force for this beat and
  // work out where the raster counters go next
  always_comb begin
    frame_start = din_valid && (col == '0) && (row == '0);
    w_eff       = frame_start ? CW'(layer_width(state)) : w_reg;
    b           = (din >= thresh);
    h           = hreg | b;
    last_col    = (col == w_eff - CW'(1));
    last_row    = (row == w_eff - CW'(1));
    col_nxt     = col;
    row_nxt     = row;
    if (din_valid) begin
      if (last_col) begin
        col_nxt = '0;
        row_nxt = last_row ? '0 : row + CW'(1);
      end else begin
        col_nxt = col + CW'(1);
      end
    end
    lb_idx   = AW'(col >> 1);
    lb_we    = din_valid && col[0] && !row[0];
    pair_out = din_valid && col[0] && row[0];
  end

  pool_line_buf #(
    .DEPTH (MAX_W / POOL),
    .AW    (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_idx),
    .wdata (h),
    .raddr (lb_idx),
    .rdata (lb_rd)
  );

  // Raster counters, width latch, horizontal pair register and the
  // early-end-of-frame check, which sees the counters after this beat
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col       <= '0;
      row       <= '0;
      hreg      <= 1'b0;
      w_reg     <= CW'(W_L1);
      frame_err <= 1'b0;
    end else begin
      if (frame_start) w_reg <= w_eff;
      if (din_valid && !col[0]) hreg <= b;
      if (din_done && !((col_nxt == '0) && (row_nxt == '0))) begin
        frame_err <= 1'b1;
        col       <= '0;
        row       <= '0;
        hreg      <= 1'b0;
      end else begin
        col <= col_nxt;
        row <= row_nxt;
      end
    end
  end

  // Registered pooled output, produced on odd-row/odd-col beats
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pool_out   <= 1'b0;
      pool_valid <= 1'b0;
      pool_done  <= 1'b0;
    end else begin
      pool_valid <= pair_out;
      pool_done  <= pair_out && last_col && last_row;
      if (pair_out) pool_out <= lb_rd | h;
    end
  end

endmodule

// File: tb/tb_bin_maxpool.sv
// Directed self-checking bench for bin_maxpool with a scoreboard fed from
// a binary-map model of the pooling operation.
module tb_bin_maxpool;
  import bnn_pkg::*;

  logic              clk = 1'b0;
  logic              rstn;
  logic              state;
  logic signed [4:0] thresh;
  logic signed [4:0] din;
  logic              din_valid;
  logic              din_done;
  logic              pool_out;
  logic              pool_valid;
  logic              pool_done;
  logic              frame_err;

  bin_maxpool #(.DW(5), .MAX_W(26)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .state      (state),
    .thresh     (thresh),
    .din        (din),
    .din_valid  (din_valid),
    .din_done   (din_done),
    .pool_out   (pool_out),
    .pool_valid (pool_valid),
    .pool_done  (pool_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int         nChecks = 0;
  int         nFails  = 0;
  logic [1:0] sb[$];
  int         doneIdx[$];
  int         outCount  = 0;
  int         onesCount = 0;
  bit         bMap[26][26];
  int         tbCol = 0;
  int         tbRow = 0;
  int         tbW   = 26;
  bit         expErr = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Test pattern value at (r, c) of a map of width w
  function automatic logic signed [4:0] pixel(input int pat, input int r, input int c, input int w);
    case (pat)
      0:       return (r < 2 && c < 2) ? -5'sd3 : 5'sd1;
      1:       return (r == w - 1 && c == w - 1) ? 5'sd2 : -5'sd1;
      2:       return -5'sd5;
      3:       return -5'sd6;
      default: return 5'sd1;
    endcase
  endfunction

  // Drive one cycle and advance the reference model
  task automatic applyStimulus(input logic v, input logic signed [4:0] d, input logic dn);
    logic e;
    din_valid = v;
    din       = d;
    din_done  = dn;
    if (v) begin
      if (tbCol == 0 && tbRow == 0) tbW = state ? 24 : 26;
      bMap[tbRow][tbCol] = (d >= thresh);
      if (tbRow % 2 == 1 && tbCol % 2 == 1) begin
        e = bMap[tbRow-1][tbCol-1] | bMap[tbRow-1][tbCol] | bMap[tbRow][tbCol-1] | bMap[tbRow][tbCol];
        sb.push_back({e, (tbRow == tbW - 1) && (tbCol == tbW - 1)});
      end
      tbCol++;
      if (tbCol == tbW) begin
        tbCol = 0;
        tbRow++;
        if (tbRow == tbW) tbRow = 0;
      end
    end
    if (dn && !(tbCol == 0 && tbRow == 0)) begin
      expErr = 1'b1;
      tbCol  = 0;
      tbRow  = 0;
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_done  = 1'b0;
    din       = '0;
  endtask

  task automatic sendBeats(input int pat, input int w, input int first, input int n,
                           input int gapEvery, input bit doneLast);
    for (int i = first; i < first + n; i++) begin
      applyStimulus(1'b1, pixel(pat, i / w, i % w, w), doneLast && (i == first + n - 1));
      if (gapEvery > 0 && (i + 1) % gapEvery == 0) begin
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
      end
    end
  endtask

  task automatic endFrame(input string tag, input int expCount, input int expOnes, input int expDones);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput({tag, "_count"}, outCount, expCount);
    checkOutput({tag, "_ones"}, onesCount, expOnes);
    checkOutput({tag, "_dones"}, doneIdx.size(), expDones);
    checkOutput({tag, "_sb_empty"}, sb.size(), 0);
    checkOutput({tag, "_frame_err"}, frame_err, expErr);
    outCount  = 0;
    onesCount = 0;
    doneIdx.delete();
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    logic [1:0] e;
    if (rstn === 1'b1) begin
      if (pool_valid === 1'b1) begin
        outCount++;
        if (pool_out === 1'b1) onesCount++;
        if (pool_done === 1'b1) doneIdx.push_back(outCount);
        checkOutput("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("pool_out", pool_out, e[1]);
          checkOutput("pool_done", pool_done, e[0]);
        end
      end else begin
        checkOutput("done_without_valid", pool_done, 0);
      end
    end
  end

  initial begin
    rstn      = 1'b0;
    state     = LAYER1;
    thresh    = '0;
    din       = '0;
    din_valid = 1'b0;
    din_done  = 1'b0;
    #1;
    checkOutput("rst_pool_out", pool_out, 0);
    checkOutput("rst_pool_valid", pool_valid, 0);
    checkOutput("rst_pool_done", pool_done, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] layer 1 full frame");
    state  = LAYER1;
    thresh = 5'sd0;
    sendBeats(0, 26, 0, 676, 0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    endFrame("l1", 169, 168, 1);
    checkOutput("l1_done_idx", doneIdx.size() == 0, 1);

    $display("[TB] layer 2 with gaps, done with last beat");
    state  = LAYER2;
    thresh = 5'sd2;
    sendBeats(1, 24, 0, 576, 24, 1'b1);
    endFrame("l2", 144, 1, 1);

    $display("[TB] threshold boundary");
    state  = LAYER1;
    thresh = -5'sd5;
    sendBeats(2, 26, 0, 676, 0, 1'b0);
    endFrame("th_eq", 169, 169, 1);
    sendBeats(3, 26, 0, 676, 0, 1'b0);
    endFrame("th_below", 169, 0, 1);

    $display("[TB] early done");
    thresh = 5'sd0;
    sendBeats(4, 26, 0, 100, 0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("early_err_set", frame_err, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0);
    endFrame("early", 24, 24, 0);
    sendBeats(4, 26, 0, 676, 0, 1'b0);
    endFrame("after_err", 169, 169, 1);

    $display("[TB] reset mid frame");
    sendBeats(4, 26, 0, 300, 0, 1'b0);
    checkOutput("pre_reset_valid", pool_valid, 1);
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst_pool_out", pool_out, 0);
    checkOutput("mid_rst_pool_valid", pool_valid, 0);
    checkOutput("mid_rst_frame_err", frame_err, 0);
    sb.delete();
    doneIdx.delete();
    outCount  = 0;
    onesCount = 0;
    tbCol     = 0;
    tbRow     = 0;
    tbW       = 26;
    expErr    = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] state change mid frame");
    state = LAYER1;
    sendBeats(4, 26, 0, 100, 0, 1'b0);
    state = LAYER2;
    sendBeats(4, 26, 100, 576, 0, 1'b0);
    endFrame("latched_w", 169, 169, 1);
    sendBeats(4, 24, 0, 576, 0, 1'b0);
    endFrame("new_w", 144, 144, 1);

    $display("[TB] back-to-back frames");
    state = LAYER1;
    sendBeats(4, 26, 0, 676, 0, 1'b0);
    sendBeats(0, 26, 0, 676, 0, 1'b0);
    if (doneIdx.size() == 2) checkOutput("b2b_done_spacing", doneIdx[1] - doneIdx[0], 169);
    endFrame("b2b", 338, 337, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/bin_maxpool.md
# bin_maxpool

Downstream stage of the binary convolution engine. It takes the signed 5-bit convolution stream, binarizes each sample against a threshold, and performs 2×2 stride-2 max pooling on the binary map. The result is a 1-bit pooled stream for the next layer's sliding-window buffer. One instance serves both conv layers, selected by `state`: layer 1 uses a 26×26 map, layer 2 uses a 24×24 map.

## Interface
Parameters:
- `DW`, 5, width of the signed convolution sample.
- `MAX_W`, 26, largest supported conv output map width; it sizes the line buffer at `MAX_W/2` bits.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `state`  in  1  layer select: 0 gives W=26, 1 gives W=24. Latched at frame start.
- `thresh`  in  DW  signed binarization threshold. Quasi-static; must not change while a frame is active.
- `din`  in  DW  signed conv sample.
- `din_valid`  in  1  `din` is valid this cycle. Gaps between beats are allowed.
- `din_done`  in  1  one-cycle pulse from the conv stage marking end of frame.
- `pool_out`  out  1  pooled binary pixel.
- `pool_valid`  out  1  `pool_out` is valid this cycle.
- `pool_done`  out  1  one-cycle pulse, asserted with the last pooled pixel of a frame.
- `frame_err`  out  1  sticky flag: `din_done` arrived with an incomplete frame. Cleared only by reset.

## Operation
- Binarize each beat: `b = (din >= thresh)`, compared as signed. `din = thresh` gives 1.
- Counters `col` and `row` both run 0..W-1.
  - They advance only on `din_valid` beats, so gap cycles are ignored.
  - `col` wraps W-1 → 0 and increments `row`.
  - `row` wraps W-1 → 0, which ends the frame.
- Frame start is a `din_valid` beat with `col=0` and `row=0`. On that beat W is latched from `state`; W is held until the frame completes.
- Horizontal pairing:
  - Even `col`: `hreg <= b`.
  - Odd `col`: `h = hreg | b`.
- Vertical pairing, on odd `col` beats only:
  - Even `row`: `lb[col>>1] <= h`.
  - Odd `row`: `pool_out <= lb[col>>1] | h` and `pool_valid <= 1`.
- Output count per frame: 169 pixels for W=26, 144 for W=24, in raster order.
- `pool_done` asserts together with the pooled pixel produced on beat (row W-1, col W-1).
- `din_done` handling:
  - With counters at (0,0), meaning the frame is complete, it is ignored.
  - Otherwise, set `frame_err` and clear `col`, `row` and `hreg` in the same cycle. No `pool_valid` is generated for the partial pair.
- `din_valid` and `din_done` in the same cycle: process the beat first, then apply the `din_done` check to the updated counters.
- The line buffer is not cleared between frames. Every entry is written on an even row before it is read on the next odd row.

## Timing
- Reset values: `pool_out=0`, `pool_valid=0`, `pool_done=0`, `frame_err=0`. Internal state resets as follows:
  - `col`, `row` and `hreg` are 0.
  - W is 26.
  - The line buffer needs no reset.
- Latency: 1 cycle from the odd-row/odd-col input beat to `pool_valid`, with registered outputs.
- `pool_valid` and `pool_done` are single-cycle strobes. Throughput is at most one output per two input beats.
- No backpressure: downstream must accept every `pool_valid`.
- Back-to-back frames are supported with no idle cycle. The next (0,0) beat re-latches W.
- Async reset mid-frame drops the partial frame immediately. Outputs go to reset values in the same cycle.

## Structure
- Shared package `bnn_pkg` holds:
  - `CONV_DW=5`
  - `W_L1=26`, `W_L2=24`
  - `POOL=2`
  - `LAYER1=1'b0`, `LAYER2=1'b1`
- Sub-module `pool_line_buf`: `MAX_W/2` × 1-bit register array.
  - One synchronous write port.
  - One combinational read port.
  - Index width `$clog2(MAX_W/2)`.
- Counters, pairing logic and error logic live in the top module. Target size is about 150–250 lines of RTL.

## Test plan
- **Layer 1 full frame.** `state=0`, `thresh=0`, 676 contiguous beats with `din=+1` everywhere except `din=-3` at (row 0, col 0..1) and (row 1, col 0..1).
  - Expect 169 `pool_valid`.
  - First `pool_out=0`, all others 1.
  - `pool_done` on the 169th output, 1 cycle after the last beat.
- **Layer 2 with gaps.** `state=1`, `thresh=2`, `din=2` only at (row 23, col 23), else `din=-1`; 2-cycle gaps every 24 beats.
  - Expect 144 outputs: 143 zeros, last output =1 with `pool_done`.
- **Threshold boundary.** `thresh=-5`, `din=-5` everywhere → all outputs 1. `din=-6` everywhere → all outputs 0.
- **Early done.** `din_done` after 100 beats → `frame_err=1`, no further output. A following complete 676-beat frame yields 169 outputs, with `frame_err` still 1.
- **Reset and state change.** Reset asserted at beat 300 → outputs 0 in the same cycle. Then `state` toggled mid-frame without reset → W stays as latched, the frame yields its original count, and the next frame uses the new W.
- **Back-to-back frames.** Two layer-1 frames with no idle cycle → 338 outputs, 2 `pool_done` pulses, 169 outputs apart.
